ysyx_22050612_exu_pipe: RTL

Parametrised, handshaked execute stage for the ysyx_22050612 RV64 core. It sits between the decode/register-read stage and writeback, and accepts one operation at a time over a valid/ready interface. Single-cycle ALU operations, an iterative shift-add multiplier and a restoring divider share one output register. The output register also carries rd, the write-enable and the sequential next-PC.

---
 rtl/ysyx_22050612_exu_pipe_pkg.sv | 33 +++
 rtl/ysyx_22050612_exu_pipe_muldiv.sv | 109 ++++++++++
 rtl/ysyx_22050612_exu_pipe.sv | 151 +++++++++++++++
 3 files changed

// File: rtl/ysyx_22050612_exu_pipe_pkg.sv
// Shared types for the execute stage.
//   op_e          : 4-bit operation code carried on in_op
//   state_e       : execute-stage FSM states
//   is_multicycle : true for ops served by the iterative mul/div unit
package exu_pkg;

  typedef enum logic [3:0] {
    OP_ADD   = 4'd0,
    OP_SUB   = 4'd1,
    OP_AND   = 4'd2,
    OP_OR    = 4'd3,
    OP_XOR   = 4'd4,
    OP_SLL   = 4'd5,
    OP_SRL   = 4'd6,
    OP_SRA   = 4'd7,
    OP_SLT   = 4'd8,
    OP_SLTU  = 4'd9,
    OP_MUL   = 4'd10,
    OP_MULHU = 4'd11,
    OP_DIVU  = 4'd12,
    OP_REMU  = 4'd13
  } op_e;

  typedef enum logic {
    S_IDLE = 1'b0,
    S_BUSY = 1'b1
  } state_e;

  function automatic logic is_multicycle(input op_e op);
    return op inside {OP_MUL, OP_MULHU, OP_DIVU, OP_REMU};
  endfunction

endpackage

// File: rtl/ysyx_22050612_exu_pipe_muldiv.sv
// Iterative unsigned multiplier (MSB-first shift-add) and restoring divider.
// One iteration per cycle, XLEN iterations (XLEN/2 in word mode).
//   clk, rst_n : clock, async active-low reset
//   kill_i     : abandon the running operation
//   start_i    : latch operands and begin (op_i, word_i, src1_i, src2_i)
//   done_o     : final iteration this cycle; result_o is valid alongside it
//   result_o   : raw (not sign-extended) result of the final iteration
module ysyx_22050612_MulDiv
  import exu_pkg::*;
#(
  parameter int XLEN = 64
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            kill_i,
  input  logic            start_i,
  input  op_e             op_i,
  input  logic            word_i,
  input  logic [XLEN-1:0] src1_i,
  input  logic [XLEN-1:0] src2_i,
  output logic            done_o,
  output logic [XLEN-1:0] result_o
);

  localparam int H  = XLEN / 2;
  localparam int CW = $clog2(XLEN) + 1;

  logic [CW-1:0]     cnt_q, cnt_d;
  logic [2*XLEN-1:0] acc_q, acc_d;   // product, or remainder in the low half
  logic [XLEN-1:0]   sh_q, sh_d;     // multiplier / dividend, consumed MSB first
  logic [XLEN-1:0]   opb_q, opb_d;   // multiplicand / divisor
  logic              div_q, div_d, sel_q, sel_d, word_q, word_d;

  logic [2*XLEN-1:0] mul_acc;
  logic [XLEN:0]     rem_sh, rem_sub;
  logic [XLEN-1:0]   rem_n, a_op, b_op;
  logic              ge, start_div;

  always_comb begin
    mul_acc = {acc_q[2*XLEN-2:0], 1'b0}
            + {{XLEN{1'b0}}, opb_q & {XLEN{sh_q[XLEN-1]}}};
    rem_sh  = {acc_q[XLEN-1:0], sh_q[XLEN-1]};
    rem_sub = rem_sh - {1'b0, opb_q};
    ge      = rem_sh >= {1'b0, opb_q};
    rem_n   = ge ? rem_sub[XLEN-1:0] : rem_sh[XLEN-1:0];
  end

  // Word-mode operands sit in the upper half of the shift register so that
  // the same MSB-first loop just runs for H iterations instead of XLEN.
  always_comb begin
    start_div = op_i inside {OP_DIVU, OP_REMU};
    a_op      = start_div ? src1_i : src2_i;
    b_op      = start_div ? src2_i : src1_i;
    cnt_d  = cnt_q;
    acc_d  = acc_q;
    sh_d   = sh_q;
    opb_d  = opb_q;
    div_d  = div_q;
    sel_d  = sel_q;
    word_d = word_q;
    if (kill_i) begin
      cnt_d = '0;
    end else if (start_i) begin
      div_d  = start_div;
      sel_d  = op_i inside {OP_MULHU, OP_REMU};
      word_d = word_i;
      cnt_d  = word_i ? CW'(H) : CW'(XLEN);
      acc_d  = '0;
      sh_d   = word_i ? {a_op[H-1:0], {H{1'b0}}} : a_op;
      opb_d  = word_i ? {{H{1'b0}}, b_op[H-1:0]} : b_op;
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - CW'(1);
      sh_d  = {sh_q[XLEN-2:0], div_q & ge};
      acc_d = div_q ? {{XLEN{1'b0}}, rem_n} : mul_acc;
    end
  end

  always_comb begin
    done_o = (cnt_q == CW'(1));
    case ({div_q, sel_q})
      2'b00:   result_o = mul_acc[XLEN-1:0];
      2'b01:   result_o = word_q ? {{H{1'b0}}, mul_acc[XLEN-1:H]}
                                 : mul_acc[2*XLEN-1:XLEN];
      2'b10:   result_o = {sh_q[XLEN-2:0], ge};
      default: result_o = rem_n;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q  <= '0;
      acc_q  <= '0;
      sh_q   <= '0;
      opb_q  <= '0;
      div_q  <= 1'b0;
      sel_q  <= 1'b0;
      word_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      acc_q  <= acc_d;
      sh_q   <= sh_d;
      opb_q  <= opb_d;
      div_q  <= div_d;
      sel_q  <= sel_d;
      word_q <= word_d;
    end
  end

endmodule

// File: rtl/ysyx_22050612_exu_pipe.sv
// Handshaked RV64 execute stage: single-cycle ALU plus iterative mul/div,
// sharing one output register that also carries rd, wen and next-PC.
//   in_*   : request (valid/ready), op, word mode, operands, rd, wen, pc
//   out_*  : result (valid/ready), result, rd, wen (0 for x0), pc + 4
//   flush  : drop the in-flight op and any held result
module ysyx_22050612_exu_pipe
  import exu_pkg::*;
#(
  parameter int XLEN   = 64,
  parameter int REG_AW = 5
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [3:0]        in_op,
  input  logic              in_word,
  input  logic [XLEN-1:0]   in_src1,
  input  logic [XLEN-1:0]   in_src2,
  input  logic [REG_AW-1:0] in_rd,
  input  logic              in_wen,
  input  logic [XLEN-1:0]   in_pc,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [XLEN-1:0]   out_result,
  output logic [REG_AW-1:0] out_rd,
  output logic              out_wen,
  output logic [XLEN-1:0]   out_dnpc
);

  localparam int H  = XLEN / 2;
  localparam int LG = $clog2(XLEN);

  state_e            state_q, state_d;
  logic              valid_q, valid_d, wen_q, wen_d, word_q, word_d;
  logic [XLEN-1:0]   result_q, result_d, dnpc_q, dnpc_d;
  logic [REG_AW-1:0] rd_q, rd_d;

  op_e             op;
  logic            accept, start, md_done;
  logic [XLEN-1:0] md_res, alu_res, raw, sa, sb, ua, ub;
  logic [LG-1:0]   shamt;

  function automatic logic [XLEN-1:0] wext(input logic [XLEN-1:0] v);
    return {{H{v[H-1]}}, v[H-1:0]};
  endfunction

  assign op       = op_e'(in_op);
  assign in_ready = !flush && (state_q == S_IDLE) && (!valid_q || out_ready);
  assign accept   = in_valid && in_ready;
  assign start    = accept && is_multicycle(op);

  // ALU: word-mode results are formed at full width then sign-extended
  // from bit H-1; only shifts and compares need the truncated operands.
  always_comb begin
    sa    = in_word ? wext(in_src1) : in_src1;
    sb    = in_word ? wext(in_src2) : in_src2;
    ua    = in_word ? {{H{1'b0}}, in_src1[H-1:0]} : in_src1;
    ub    = in_word ? {{H{1'b0}}, in_src2[H-1:0]} : in_src2;
    shamt = in_word ? {1'b0, in_src2[LG-2:0]} : in_src2[LG-1:0];
    case (op)
      OP_ADD:  raw = in_src1 + in_src2;
      OP_SUB:  raw = in_src1 - in_src2;
      OP_AND:  raw = in_src1 & in_src2;
      OP_OR:   raw = in_src1 | in_src2;
      OP_XOR:  raw = in_src1 ^ in_src2;
      OP_SLL:  raw = in_src1 << shamt;
      OP_SRL:  raw = ua >> shamt;
      OP_SRA:  raw = $signed(sa) >>> shamt;
      OP_SLT:  raw = {{(XLEN-1){1'b0}}, $signed(sa) < $signed(sb)};
      OP_SLTU: raw = {{(XLEN-1){1'b0}}, ua < ub};
      default: raw = '0;
    endcase
    alu_res = in_word ? wext(raw) : raw;
  end

  ysyx_22050612_MulDiv #(.XLEN(XLEN)) u_muldiv (
    .clk      (clk),
    .rst_n    (rst_n),
    .kill_i   (flush),
    .start_i  (start),
    .op_i     (op),
    .word_i   (in_word),
    .src1_i   (in_src1),
    .src2_i   (in_src2),
    .done_o   (md_done),
    .result_o (md_res)
  );

  // rd/wen/dnpc are captured at accept even for mul/div; out_valid stays low
  // until the unit finishes, so the consumer never sees them early.
  always_comb begin
    state_d  = state_q;
    valid_d  = valid_q;
    result_d = result_q;
    rd_d     = rd_q;
    wen_d    = wen_q;
    dnpc_d   = dnpc_q;
    word_d   = word_q;
    if (flush) begin
      state_d = S_IDLE;
      valid_d = 1'b0;
    end else if (accept) begin
      rd_d   = in_rd;
      wen_d  = in_wen && (in_rd != '0);
      dnpc_d = in_pc + XLEN'(4);
      word_d = in_word;
      if (is_multicycle(op)) begin
        state_d = S_BUSY;
        valid_d = 1'b0;
      end else begin
        result_d = alu_res;
        valid_d  = 1'b1;
      end
    end else if (state_q == S_BUSY && md_done) begin
      state_d  = S_IDLE;
      result_d = word_q ? wext(md_res) : md_res;
      valid_d  = 1'b1;
    end else if (out_ready) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      valid_q  <= 1'b0;
      result_q <= '0;
      rd_q     <= '0;
      wen_q    <= 1'b0;
      dnpc_q   <= '0;
      word_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      valid_q  <= valid_d;
      result_q <= result_d;
      rd_q     <= rd_d;
      wen_q    <= wen_d;
      dnpc_q   <= dnpc_d;
      word_q   <= word_d;
    end
  end

  assign out_valid  = valid_q;
  assign out_result = result_q;
  assign out_rd     = rd_q;
  assign out_wen    = wen_q;
  assign out_dnpc   = dnpc_q;

endmodule
